glb_port_arbiter: RTL

//  Shares the single-read/single-write GLB SRAM (MEM32x16384) among the accelerator's DMA clients.

---
 rtl/glb_port_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/glb_port_arbiter.sv
// glb_port_arbiter
//  Shares the single-read / single-write GLB SRAM among the DMA clients.
//  Read clients (weight, ifmap, bias) and write clients (opsum, spill) are each
//  arbitrated round-robin; byte addresses become word addresses and byte
//  strobes expand to active-low BWEB bit enables.  Read responses are tagged
//  and returned to the issuing client RD_LAT cycles after the grant.
//  A write with any strobe set blocks a same-cycle read of the same word, so
//  the read retries next cycle and observes the written data.
//  Optional feature macro: GLB_ARB_WEIGHT_PRIO_EN -- read client 0 gets strict
//  priority; the rotating pointer then covers clients 1..NUM_RD-1 only.
module glb_port_arbiter #(
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD-1:0]            rd_req_valid,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_req_addr,
  output logic [NUM_RD-1:0]            rd_req_ready,
  output logic [NUM_RD-1:0]            rd_rsp_valid,
  output logic [DATA_W-1:0]            rd_rsp_data,
  input  logic [NUM_WR-1:0]            wr_req_valid,
  input  logic [NUM_WR*ADDR_W-1:0]     wr_req_addr,
  input  logic [NUM_WR*DATA_W-1:0]     wr_req_data,
  input  logic [NUM_WR*(DATA_W/8)-1:0] wr_req_strb,
  output logic [NUM_WR-1:0]            wr_req_ready,
  output logic                         sram_re,
  output logic [ADDR_W-3:0]            sram_r_addr,
  input  logic [DATA_W-1:0]            sram_d_out,
  output logic                         sram_web,
  output logic [DATA_W-1:0]            sram_bweb,
  output logic [ADDR_W-3:0]            sram_w_addr,
  output logic [DATA_W-1:0]            sram_d_in,
  output logic                         err_misalign,
  input  logic                         err_clr
);

  localparam int NB     = DATA_W / 8;
  localparam int RIDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int WIDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  logic [RIDX_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [WIDX_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic              err_reg, err_next;

  logic              rd_found, wr_found;
  logic [RIDX_W-1:0] rd_sel;
  logic [WIDX_W-1:0] wr_sel;
  logic [ADDR_W-1:0] rd_addr_sel, wr_addr_sel;
  logic [DATA_W-1:0] wr_data_sel;
  logic [NB-1:0]     wr_strb_sel;
  logic              rd_go, wr_go, wr_active, collision, err_set;

  logic [RD_LAT-1:0]             tag_vld_reg;
  logic [RD_LAT-1:0][RIDX_W-1:0] tag_idx_reg;

  // Read winner: first requesting client at or after the rotating pointer
  always_comb begin : rd_pick_comb
    int idx;
    logic [RIDX_W-1:0] cand;
    idx      = 0;
    cand     = '0;
    rd_found = 1'b0;
    rd_sel   = '0;
`ifdef GLB_ARB_WEIGHT_PRIO_EN
    if (rd_req_valid[0]) begin
      rd_found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_RD - 1; k++) begin
        // pointer value 0 (reset) behaves as client 1
        idx = ((rd_ptr_reg == '0) ? 1 : int'(rd_ptr_reg)) + k;
        if (idx >= NUM_RD) idx = idx - (NUM_RD - 1);
        cand = RIDX_W'(idx);
        if (!rd_found && rd_req_valid[cand]) begin
          rd_found = 1'b1;
          rd_sel   = cand;
        end
      end
    end
`else
    for (int k = 0; k < NUM_RD; k++) begin
      idx  = (int'(rd_ptr_reg) + k) % NUM_RD;
      cand = RIDX_W'(idx);
      if (!rd_found && rd_req_valid[cand]) begin
        rd_found = 1'b1;
        rd_sel   = cand;
      end
    end
`endif
  end

  // Write winner: independent round-robin over the write clients
  always_comb begin : wr_pick_comb
    int idx;
    logic [WIDX_W-1:0] cand;
    idx      = 0;
    cand     = '0;
    wr_found = 1'b0;
    wr_sel   = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      idx  = (int'(wr_ptr_reg) + k) % NUM_WR;
      cand = WIDX_W'(idx);
      if (!wr_found && wr_req_valid[cand]) begin
        wr_found = 1'b1;
        wr_sel   = cand;
      end
    end
  end

  assign rd_addr_sel = rd_req_addr[int'(rd_sel)*ADDR_W +: ADDR_W];
  assign wr_addr_sel = wr_req_addr[int'(wr_sel)*ADDR_W +: ADDR_W];
  assign wr_data_sel = wr_req_data[int'(wr_sel)*DATA_W +: DATA_W];
  assign wr_strb_sel = wr_req_strb[int'(wr_sel)*NB +: NB];

  // A zero-strobe write is consumed but never touches the SRAM, so it cannot collide
  assign wr_go     = wr_found & ~rst;
  assign wr_active = wr_go & (|wr_strb_sel);
  assign collision = wr_active & rd_found &
                     (rd_addr_sel[ADDR_W-1:2] == wr_addr_sel[ADDR_W-1:2]);
  assign rd_go     = rd_found & ~rst & ~collision;

  assign sram_re     = rd_go;
  assign sram_r_addr = rd_go ? rd_addr_sel[ADDR_W-1:2] : '0;
  assign sram_web    = ~wr_active;
  assign sram_w_addr = wr_go ? wr_addr_sel[ADDR_W-1:2] : '0;
  assign sram_d_in   = wr_go ? wr_data_sel : '0;
  assign rd_rsp_data = sram_d_out;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
      assign rd_req_ready[gi] = rd_go & (rd_sel == RIDX_W'(gi));
      assign rd_rsp_valid[gi] = ~rst & tag_vld_reg[RD_LAT-1] &
                                (tag_idx_reg[RD_LAT-1] == RIDX_W'(gi));
    end
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_port
      assign wr_req_ready[gi] = wr_go & (wr_sel == WIDX_W'(gi));
    end
    for (gi = 0; gi < NB; gi++) begin : g_bweb
      assign sram_bweb[gi*8 +: 8] = {8{~(wr_active & wr_strb_sel[gi])}};
    end
  endgenerate

  // Pointer advance after a grant; a stalled or absent read leaves rd_ptr alone
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (rd_go) begin
`ifdef GLB_ARB_WEIGHT_PRIO_EN
      if (rd_sel != '0)
        rd_ptr_next = (int'(rd_sel) == NUM_RD - 1) ? RIDX_W'(1) : rd_sel + RIDX_W'(1);
`else
      rd_ptr_next = (int'(rd_sel) == NUM_RD - 1) ? '0 : rd_sel + RIDX_W'(1);
`endif
    end
    if (wr_go)
      wr_ptr_next = (int'(wr_sel) == NUM_WR - 1) ? '0 : wr_sel + WIDX_W'(1);
  end

  // Sticky misalignment flag; a new error in the clear cycle keeps it set
  assign err_set  = (rd_go & (|rd_addr_sel[1:0])) | (wr_go & (|wr_addr_sel[1:0]));
  assign err_next = err_set ? 1'b1 : (err_clr ? 1'b0 : err_reg);
  assign err_misalign = err_reg & ~rst;

  // Arbitration state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      err_reg    <= err_next;
    end
  end

  // Response tag pipeline: the last stage lines up with valid SRAM read data
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_reg <= '0;
      tag_idx_reg <= '0;
    end else begin
      tag_vld_reg[0] <= rd_go;
      tag_idx_reg[0] <= rd_sel;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_vld_reg[s] <= tag_vld_reg[s-1];
        tag_idx_reg[s] <= tag_idx_reg[s-1];
      end
    end
  end

endmodule
